pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_stall_ctrl_if.sv | 35 +++
 rtl/pipe_stall_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/stall handshake bundle between the pipeline datapath and
// pipe_stall_ctrl.
//   master : datapath side, drives the hazard inputs, receives enables/bubble/flush
//   slave  : controller side
// Parameter REG_W : register-specifier width.
interface pipe_stall_ctrl_if #(
  parameter int REG_W = 4
);
  logic [REG_W-1:0] id_src_reg1;
  logic [REG_W-1:0] id_src_reg2;
  logic [REG_W-1:0] ex_dest_reg;
  logic             id_uses_src2;
  logic             ex_mem_read;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IDEXWrite;
  logic             EXMEMWrite;
  logic             ST;
  logic             FLUSH_IFID;

  modport master (
    output id_src_reg1, id_src_reg2, ex_dest_reg, id_uses_src2, ex_mem_read,
           branch_taken, mem_req, mem_ready,
    input  PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, ST, FLUSH_IFID
  );

  modport slave (
    input  id_src_reg1, id_src_reg2, ex_dest_reg, id_uses_src2, ex_mem_read,
           branch_taken, mem_req, mem_ready,
    output PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, ST, FLUSH_IFID
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: memory-wait stalls, taken-branch flushes
// and load-use bubbles, with a sticky memory-timeout flag.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus (slave)   : hazard inputs in, write enables / ST / FLUSH_IFID out
//   perf_clr      : synchronous clear of the performance counters
//   mem_timeout   : sticky, set when a memory wait reaches MEM_TIMEOUT cycles
//   stall_cycles  : cycles with PCWrite=0 (saturating)
//   flush_count   : cycles with FLUSH_IFID=1 (saturating)
// Build option: define PIPE_STALL_PERF_EN to include the performance
// counters; otherwise they read as zero and perf_clr is ignored.
module pipe_stall_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int REG_W       = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipe_stall_ctrl_if.slave        bus,
  input  logic                    perf_clr,
  output logic                    mem_timeout,
  output logic [15:0]             stall_cycles,
  output logic [15:0]             flush_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH, LU_STALL} state_t;

  localparam logic [7:0] TO_LIM = MEM_TIMEOUT[7:0];

  state_t           state, state_nxt;
  logic [7:0]       wait_cnt, wait_inc;
  logic [REG_W-1:0] dest;
  logic             mem_stall, lu_hit;
  logic             pc_we, ifid_we, idex_we, exmem_we, st, flush;

  assign dest      = bus.ex_dest_reg;
  assign mem_stall = bus.mem_req & ~bus.mem_ready;
  assign lu_hit    = bus.ex_mem_read &
                     ((dest == bus.id_src_reg1) |
                      (bus.id_uses_src2 & (dest == bus.id_src_reg2)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Priority: memory stall, then branch flush, then load-use bubble.
  // Load-use detection only runs from RUN; the cycle after a bubble or a
  // flush, and the release cycle of a memory wait, never re-detect.
  always_comb begin
    pc_we     = 1'b1;
    ifid_we   = 1'b1;
    idex_we   = 1'b1;
    exmem_we  = 1'b1;
    st        = 1'b0;
    flush     = 1'b0;
    state_nxt = RUN;
    if (mem_stall) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      idex_we   = 1'b0;
      exmem_we  = 1'b0;
      state_nxt = MEM_WAIT;
    end else if (bus.branch_taken) begin
      st        = 1'b1;
      flush     = 1'b1;
      state_nxt = FLUSH;
    end else if (state == RUN && lu_hit) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      st        = 1'b1;
      state_nxt = LU_STALL;
    end
  end

  assign bus.PCWrite    = pc_we;
  assign bus.IFIDWrite  = ifid_we;
  assign bus.IDEXWrite  = idex_we;
  assign bus.EXMEMWrite = exmem_we;
  assign bus.ST         = st;
  assign bus.FLUSH_IFID = flush;

  // Wait counter counts every stalled cycle (the entry cycle included), so
  // the flag rises on the same edge the count reaches the limit.
  assign wait_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (mem_stall) begin
      wait_cnt <= wait_inc;
      if (wait_inc == TO_LIM) mem_timeout <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

`ifdef PIPE_STALL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_we && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      if (flush  && flush_count  != 16'hFFFF) flush_count  <= flush_count  + 16'd1;
    end
  end
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign stall_cycles    = '0;
  assign flush_count     = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed vector table, multi-cycle corner
// sequences, then random traffic against a behavioural model.
module tb_pipe_stall_ctrl;
  localparam int TO = 8;

  logic        clk, rst_n, perf_clr, mem_timeout;
  logic [15:0] stall_cycles, flush_count;
  int          checks = 0, errors = 0;

  pipe_stall_ctrl_if #(.REG_W(4)) bus ();

  pipe_stall_ctrl #(.MEM_TIMEOUT(TO), .REG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .perf_clr(perf_clr),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] s1, s2, d;
    logic       u2, mrd, br, mreq, mrdy;
    logic [5:0] exp; // {PCWrite,IFIDWrite,IDEXWrite,EXMEMWrite,ST,FLUSH_IFID}
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(int s1, int s2, int u2, int d, int mrd, int br,
                              int mreq, int mrdy, logic [5:0] e);
    vec_t v;
    v.s1 = 4'(s1); v.s2 = 4'(s2); v.d = 4'(d);
    v.u2 = 1'(u2); v.mrd = 1'(mrd); v.br = 1'(br);
    v.mreq = 1'(mreq); v.mrdy = 1'(mrdy); v.exp = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.id_src_reg1 = v.s1; bus.id_src_reg2 = v.s2; bus.ex_dest_reg = v.d;
    bus.id_uses_src2 = v.u2; bus.ex_mem_read = v.mrd; bus.branch_taken = v.br;
    bus.mem_req = v.mreq; bus.mem_ready = v.mrdy;
  endtask

  function automatic logic [5:0] outs();
    return {bus.PCWrite, bus.IFIDWrite, bus.IDEXWrite, bus.EXMEMWrite, bus.ST, bus.FLUSH_IFID};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: remembers what the previous cycle did, not a state code.
  bit m_wait, m_fl, m_lu, m_to;
  int m_cnt, m_sc, m_fc;

  task automatic model_reset();
    m_wait = 0; m_fl = 0; m_lu = 0; m_to = 0; m_cnt = 0; m_sc = 0; m_fc = 0;
  endtask

  function automatic logic [5:0] ref_outs();
    bit ms, hit;
    ms  = bus.mem_req && !bus.mem_ready;
    hit = bus.ex_mem_read && ((bus.ex_dest_reg == bus.id_src_reg1) ||
          (bus.id_uses_src2 && bus.ex_dest_reg == bus.id_src_reg2));
    if (ms) return 6'b000000;
    if (bus.branch_taken) return 6'b111111;
    if (hit && !(m_wait || m_fl || m_lu)) return 6'b001110;
    return 6'b111100;
  endfunction

  task automatic model_step(input logic [5:0] o);
    bit ms;
    ms = bus.mem_req && !bus.mem_ready;
`ifdef PIPE_STALL_PERF_EN
    if (perf_clr) begin
      m_sc = 0; m_fc = 0;
    end else begin
      if (!o[5] && m_sc < 65535) m_sc++;
      if (o[0] && m_fc < 65535) m_fc++;
    end
`endif
    if (ms) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt == TO) m_to = 1;
    end else m_cnt = 0;
    m_wait = ms;
    m_fl   = o[0];
    m_lu   = !o[5] && !ms;
  endtask

  vec_t idle, hitv;
  logic [5:0] e;

  initial begin
    //          s1 s2 u2 d mrd br mreq mrdy exp
    tbl[0]  = mk(1, 0, 0, 2, 1, 0, 0, 0, 6'b111100);
    tbl[1]  = mk(3, 0, 0, 3, 1, 0, 0, 0, 6'b001110);
    tbl[2]  = mk(3, 0, 0, 3, 1, 0, 0, 0, 6'b111100);
    tbl[3]  = mk(0, 5, 0, 5, 1, 0, 0, 0, 6'b111100);
    tbl[4]  = mk(0, 5, 1, 5, 1, 0, 0, 0, 6'b001110);
    tbl[5]  = mk(0, 5, 1, 5, 1, 1, 0, 0, 6'b111111);
    tbl[6]  = mk(0, 5, 1, 5, 1, 0, 0, 0, 6'b111100);
    tbl[7]  = mk(3, 0, 0, 3, 1, 1, 0, 0, 6'b111111);
    tbl[8]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 6'b111100);
    for (int i = 9; i < 13; i++) tbl[i] = mk(0, 0, 0, 1, 0, 1, 1, 0, 6'b000000);
    tbl[13] = mk(0, 0, 0, 1, 0, 1, 1, 1, 6'b111111);
    tbl[14] = mk(0, 0, 0, 1, 0, 0, 0, 0, 6'b111100);
    tbl[15] = mk(3, 0, 0, 3, 1, 1, 1, 0, 6'b000000);
    tbl[16] = mk(3, 0, 0, 3, 1, 0, 1, 1, 6'b111100);
    idle = mk(0, 0, 0, 1, 0, 0, 0, 0, 6'b111100);
    hitv = mk(3, 0, 0, 3, 1, 0, 0, 0, 6'b001110);

    // Reset state and RUN decoding while held in reset
    rst_n = 1'b0; perf_clr = 1'b0; drive(idle);
    repeat (2) tick();
    @(negedge clk);
    chk("rst_outs", 32'(outs()), 32'(6'b111100));
    chk("rst_timeout", 32'(mem_timeout), 0);
    chk("rst_stall_cnt", 32'(stall_cycles), 0);
    chk("rst_flush_cnt", 32'(flush_count), 0);
    drive(hitv);
    #1 chk("rst_run_decode", 32'(outs()), 32'(6'b001110));
    drive(idle);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_to", i), 32'(mem_timeout), 0);
      tick();
    end
`ifdef PIPE_STALL_PERF_EN
    chk("tbl_stall_cnt", 32'(stall_cycles), 7);
    chk("tbl_flush_cnt", 32'(flush_count), 3);
`else
    chk("tbl_stall_cnt", 32'(stall_cycles), 0);
    chk("tbl_flush_cnt", 32'(flush_count), 0);
`endif

    // Reset in the middle of FLUSH: no suppression left over
    drive(mk(0, 0, 0, 1, 0, 1, 0, 0, 6'b0));
    tick();
    drive(hitv);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_flush", 32'(outs()), 32'(6'b001110));
    drive(idle);
    tick();
    drive(hitv);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_run", 32'(outs()), 32'(6'b001110));
    tick();
    @(negedge clk);
    chk("release_lu_stall", 32'(outs()), 32'(6'b111100));
    tick();
    drive(idle);
    tick();

    // Sticky memory timeout at MEM_TIMEOUT wait cycles
    rst_n = 1'b0; #1 rst_n = 1'b1;
    drive(mk(0, 0, 0, 1, 0, 0, 1, 0, 6'b0));
    for (int k = 1; k <= TO; k++) begin
      tick();
      @(negedge clk);
      if (k >= TO - 1) chk($sformatf("timeout_after_%0d", k), 32'(mem_timeout), 32'(k == TO));
    end
    bus.mem_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("timeout_after_ready", 32'(mem_timeout), 1);
    drive(idle);
    repeat (2) tick();
    chk("timeout_sticky", 32'(mem_timeout), 1);
    rst_n = 1'b0;
    #1 chk("timeout_rst", 32'(mem_timeout), 0);
    rst_n = 1'b1;

    // Performance counters: 3 stalls + 1 flush, clear, reset mid-wait
    drive(mk(0, 0, 0, 1, 0, 1, 1, 0, 6'b0));
    repeat (3) tick();
    bus.mem_ready = 1'b1;
    tick();
    drive(idle);
    tick();
    @(negedge clk);
`ifdef PIPE_STALL_PERF_EN
    chk("perf_stall3", 32'(stall_cycles), 3);
    chk("perf_flush1", 32'(flush_count), 1);
`else
    chk("perf_stall3", 32'(stall_cycles), 0);
    chk("perf_flush1", 32'(flush_count), 0);
`endif
    perf_clr = 1'b1;
    drive(mk(0, 0, 0, 1, 0, 1, 1, 0, 6'b0));
    tick();
    perf_clr = 1'b0;
    chk("perf_clr_stall", 32'(stall_cycles), 0);
    chk("perf_clr_flush", 32'(flush_count), 0);
    tick();
`ifdef PIPE_STALL_PERF_EN
    chk("perf_count_again", 32'(stall_cycles), 1);
`else
    chk("perf_count_again", 32'(stall_cycles), 0);
`endif
    rst_n = 1'b0;
    #1 chk("rst_mid_wait_cnt", 32'(stall_cycles), 0);
    drive(hitv);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_wait_run", 32'(outs()), 32'(6'b001110));
    tick();

    // Random traffic against the model
    rst_n = 1'b0; model_reset(); drive(idle);
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      bus.id_src_reg1  = 4'($urandom_range(0, 3));
      bus.id_src_reg2  = 4'($urandom_range(0, 3));
      bus.ex_dest_reg  = 4'($urandom_range(0, 3));
      bus.id_uses_src2 = 1'($urandom_range(0, 1));
      bus.ex_mem_read  = 1'($urandom_range(0, 1));
      bus.branch_taken = ($urandom_range(0, 4) == 0);
      bus.mem_req      = ($urandom_range(0, 2) == 0);
      bus.mem_ready    = 1'($urandom_range(0, 1));
      perf_clr         = ($urandom_range(0, 49) == 0);
      if (!rst_n) model_reset();
      e = ref_outs();
      @(negedge clk);
      chk("rnd_outs", 32'(outs()), 32'(e));
      chk("rnd_timeout", 32'(mem_timeout), 32'(m_to));
      chk("rnd_stall_cnt", 32'(stall_cycles), 32'(m_sc));
      chk("rnd_flush_cnt", 32'(flush_count), 32'(m_fc));
      if (rst_n) model_step(e);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
